// File: rtl/mult_arb_seq.sv
// -----------------------------------------------------------------------------
// mult_arb_seq
//   Two-requester arbiter in front of a sequential shift-and-add multiplier.
//   In IDLE one requester is granted (round-robin or fixed priority). Its
//   4-bit x 3-bit operands are latched on acceptance. Three MUL cycles follow,
//   one per multiplier bit. The 7-bit product is then held in DONE until the
//   consumer takes it.
//
// Parameters
//   PRIO_FIXED   0 = round-robin, 1 = requester 0 always wins contention
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   reqN_valid   requester N holds an operand pair (N = 0,1)
//   reqN_a       requester N multiplicand, 4-bit unsigned
//   reqN_b       requester N multiplier, 3-bit unsigned
//   reqN_ready   requester N operands accepted this cycle (combinational)
//   res_valid    product available (DONE state)
//   res_data     7-bit unsigned product
//   res_id       index of the requester owning res_data
//   res_ready    consumer takes the result this cycle
//   busy         FSM is not in IDLE
// -----------------------------------------------------------------------------
module mult_arb_seq #(
   parameter int PRIO_FIXED = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0_valid,
   input  logic [3:0] req0_a,
   input  logic [2:0] req0_b,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [3:0] req1_a,
   input  logic [2:0] req1_b,
   output logic       req1_ready,
   output logic       res_valid,
   output logic [6:0] res_data,
   output logic       res_id,
   input  logic       res_ready,
   output logic       busy
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0] state_q, state_d;
   logic [3:0] a_q, a_d;
   logic [2:0] b_q, b_d;
   logic       id_q, id_d;
   logic [6:0] acc_q, acc_d;
   logic [1:0] step_q, step_d;
   logic       last_q, last_d;

   logic       gnt0, gnt1;
   logic       idle;
   logic [3:0] b_ext;
   logic [6:0] a_ext;

   assign idle = (state_q == S_IDLE);

   // Requester 0 wins when alone, under fixed priority, or when requester 1
   // was served last. Requester 1 takes whatever requester 0 does not.
   assign gnt0 = req0_valid && (!req1_valid || (PRIO_FIXED != 0) || last_q);
   assign gnt1 = req1_valid && !gnt0;

   // Gated by rst_n so no handshake is advertised while reset is held.
   assign req0_ready = rst_n && idle && gnt0;
   assign req1_ready = rst_n && idle && gnt1;

   // Padding keeps the step index in range for a 2-bit counter.
   assign b_ext = {1'b0, b_q};
   assign a_ext = {3'b000, a_q};

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      id_d    = id_q;
      acc_d   = acc_q;
      step_d  = step_q;
      last_d  = last_q;
      case (state_q)
         S_IDLE: begin
            if (gnt0 || gnt1) begin
               a_d     = gnt0 ? req0_a : req1_a;
               b_d     = gnt0 ? req0_b : req1_b;
               id_d    = gnt1;
               acc_d   = 7'd0;
               step_d  = 2'd0;
               state_d = S_MUL;
            end
         end
         S_MUL: begin
            if (b_ext[step_q])
               acc_d = acc_q + (a_ext << step_q);
            step_d = step_q + 2'd1;
            if (step_q == 2'd2)
               state_d = S_DONE;
         end
         S_DONE: begin
            if (res_ready) begin
               last_d  = id_q;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_q     <= 4'd0;
         b_q     <= 3'd0;
         id_q    <= 1'b0;
         acc_q   <= 7'd0;
         step_q  <= 2'd0;
         last_q  <= 1'b1;   // requester 0 wins the first contention
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         id_q    <= id_d;
         acc_q   <= acc_d;
         step_q  <= step_d;
         last_q  <= last_d;
      end
   end

   // Result fields are forced to zero outside DONE so nothing stale leaks out.
   assign res_valid = (state_q == S_DONE);
   assign res_data  = res_valid ? acc_q : 7'd0;
   assign res_id    = res_valid ? id_q  : 1'b0;
   assign busy      = !idle;

endmodule

// File: doc/mult_arb_seq.md
MULT_ARB_SEQ -- requirements
Module: mult_arb_seq

Interface
REQ-001 The module SHALL have one parameter: PRIO_FIXED, default 0, meaning 0 = round-robin arbitration and 1 = requester 0 always wins.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid  input  1  requester 0 holds an operand pair.
REQ-005 req0_a  input  4  requester 0 multiplicand, unsigned.
REQ-006 req0_b  input  3  requester 0 multiplier, unsigned.
REQ-007 req0_ready  output  1  requester 0 operands are accepted this cycle.
REQ-008 req1_valid, req1_a, req1_b, req1_ready SHALL match the requester-0 ports in direction and width, for requester 1.
REQ-009 res_valid  output  1  a result is available.
REQ-010 res_data  output  7  product, unsigned.
REQ-011 res_id  output  1  index of the requester that owns res_data.
REQ-012 res_ready  input  1  the consumer takes the result this cycle.
REQ-013 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, MUL and DONE.
REQ-015 An acceptance SHALL occur on a rising edge where reqN_valid and reqN_ready are both high.
REQ-016 reqN_ready SHALL be combinational, and high only in IDLE for the granted requester; both readys SHALL be low in MUL and DONE.
REQ-017 Grant in IDLE, when only one requester is valid: that requester SHALL be granted.
REQ-018 Grant in IDLE, when both are valid and PRIO_FIXED=0: the requester that differs from last_served SHALL be granted.
REQ-019 Grant in IDLE, when both are valid and PRIO_FIXED=1: requester 0 SHALL be granted.
REQ-020 Grant in IDLE, when neither is valid: no grant SHALL be made.
REQ-021 On acceptance, the module SHALL latch a_reg, b_reg and id_reg, clear acc to 0, clear the 2-bit step counter to 0, and enter MUL.
REQ-022 In MUL, on each edge with step k (0..2), acc SHALL update to acc + ({3'b0,a_reg} << k) if b_reg[k]=1, and SHALL be left unchanged otherwise.
REQ-023 In MUL, the step counter SHALL then increment; after the edge that processes k=2, the FSM SHALL enter DONE.
REQ-024 acc width SHALL be 7 bits; the maximum product is 15*7=105, so no overflow handling is required.
REQ-025 res_valid SHALL go high exactly 3 cycles after the acceptance edge and SHALL stay high until an edge where res_ready=1.
REQ-026 While in DONE, res_data SHALL equal acc and res_id SHALL equal id_reg, both stable.
REQ-027 On an edge in DONE with res_ready=1, last_served SHALL take id_reg and the FSM SHALL return to IDLE.
REQ-028 A res_ready held high in advance SHALL be honoured on the first DONE cycle, so a result is held for a minimum of 1 cycle.
REQ-029 Back-to-back throughput SHALL be one product per 5 cycles: 1 IDLE, 3 MUL, 1 DONE.
REQ-030 res_ready while not in DONE SHALL be ignored.
REQ-031 Changes on a non-granted requester's inputs SHALL have no effect.
REQ-032 reqN_valid dropping before acceptance SHALL cancel that request with no side effects.
REQ-033 Operands SHALL be sampled only at acceptance; input changes during MUL and DONE SHALL NOT affect the result.
REQ-034 A zero operand (a=0 or b=0) SHALL still take the full 3 MUL cycles and SHALL produce res_data=0.

Reset
REQ-035 While rst_n=0, the outputs SHALL be held as: state=IDLE, res_valid=0, res_data=0, res_id=0, busy=0, both readys=0.
REQ-036 While rst_n=0, the internal state SHALL be held as: acc=0, step=0, last_served=1, so requester 0 wins the first contention.
REQ-037 Assertion of rst_n mid-MUL or mid-DONE SHALL abort the operation immediately; the pending result SHALL be discarded and never presented.
REQ-038 After rst_n deasserts, the first acceptance SHALL be possible on the first rising edge.

Verification
REQ-039 Single request: req0 a=13, b=5, res_ready=1 -> res_valid high 3 cycles after acceptance, res_data=65, res_id=0, busy low the following cycle.
REQ-040 Exhaustive: all 128 (a,b) pairs via req1 -> every res_data = a*b, with a=15, b=7 giving 105 and a=0 giving 0.
REQ-041 Contention, PRIO_FIXED=0: both valid continuously from reset with distinct operands -> grants alternate 0,1,0,1 and each res_id matches the owner of its product.
REQ-042 Backpressure: res_ready=0 for 6 cycles in DONE -> res_valid, res_data and res_id stay stable, both readys stay 0, and the result completes on the first res_ready=1.
REQ-043 Reset mid-MUL: rst_n pulled low at step 1 of a=9, b=3 -> outputs clear asynchronously, no result ever appears, and the next request (a=2, b=2) returns 4.
REQ-044 Fixed priority, PRIO_FIXED=1: both valid for 3 transactions -> all 3 granted to requester 0, and req1 is served only after req0_valid drops.
